dcache_responder: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache. It is the responder side of the CPU data-memory port, i.e. the same address, read-enable, write-enable and write-data interface the pipelined CPU drives from its MEM stage.
- It returns read data on a hit and asserts stall_o on misses and writes.
- It refills and writes through to a backing word memory over a req/ack handshake.
- It keeps hit and miss counters for the cache-simulator statistics.

---
 rtl/dcache_responder.sv | 158 +++++++++++++++
 tb/tb_dcache_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting on the
// CPU MEM-stage data port. Hits answer combinationally; misses refill a whole
// line from the backing word memory, and every write goes through to memory.
module dcache_responder #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [31:0]           r_data [NUM_LINES][LINE_WORDS];
  logic [OFF_W-1:0]      r_cnt;
  logic [31:0]           r_mem_addr, r_mem_wdata;
  logic [31:0]           r_hit_cnt, r_miss_cnt;

  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx, w_ridx;
  logic [TAG_W-1:0]      w_tag, w_rtag;
  logic                  w_hit;

  // CPU-side address split, and the refill target taken from the latched base
  assign w_off  = addr_i[OFF_W+1:2];
  assign w_idx  = addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign w_tag  = addr_i[31:IDX_W+OFF_W+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ridx = r_mem_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign w_rtag = r_mem_addr[31:IDX_W+OFF_W+2];

  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign hit_cnt_o   = r_hit_cnt;
  assign miss_cnt_o  = r_miss_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next state plus stall / memory handshake / read data decode
  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    rdata_o   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (wr_i) begin
          stall_o = 1'b1;
          w_next  = S_WRITE;
        end else if (rd_i) begin
          if (w_hit) begin
            rdata_o = r_data[w_idx][w_off];
          end else begin
            stall_o = 1'b1;
            w_next  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i && r_cnt == LAST_WORD) w_next = S_DONE;
      end
      S_WRITE: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) w_next = S_DONE;
      end
      default: begin
        // line is valid now; CPU consumes the result at this edge
        rdata_o = r_data[w_idx][w_off];
        w_next  = S_IDLE;
      end
    endcase
  end

  // State, tags/valids, memory request registers and statistics counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_hit_cnt   <= 32'd0;
      r_miss_cnt  <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (wr_i) begin
            if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
            else       r_miss_cnt <= sat_inc(r_miss_cnt);
            r_mem_addr  <= {addr_i[31:2], 2'b00};
            r_mem_wdata <= wdata_i;
          end else if (rd_i) begin
            if (w_hit) begin
              r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
              r_miss_cnt     <= sat_inc(r_miss_cnt);
              r_mem_addr     <= {addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
              r_cnt          <= '0;
              // victim line is being overwritten; it must not hit mid-refill
              r_valid[w_idx] <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) begin
              r_valid[w_ridx] <= 1'b1;
              r_tag[w_ridx]   <= w_rtag;
            end else begin
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data array: write-hit update and refill fill; contents need no reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == S_IDLE && wr_i && w_hit)
        r_data[w_idx][w_off] <= wdata_i;
      else if (r_state == S_REFILL && mem_ack_i)
        r_data[w_ridx][r_cnt] <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Randomised scoreboard bench for dcache_responder: a backing-memory
// responder with variable latency, a line-level cache model, and a monitor
// that pops expected results whenever the CPU request completes.
module tb_dcache_responder;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        rd_i = 1'b0, wr_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic        stall_o, mem_req_o, mem_we_o, mem_ack_i = 1'b0;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  dcache_responder #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { bit is_rd; logic [31:0] addr; logic [31:0] data; } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  // ---------------- backing memory (shared initial image) ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] rd_log[$];
  logic [63:0] wr_log[$];
  int fixed_lat = 0, ack_cnt = 0, left = 0;
  bit busy = 1'b0;
  logic [31:0] c_addr, c_wd;
  logic        c_we;

  // Responder: latches a request, acks after 'left' cycles, checks the
  // request stays stable while it waits
  always @(negedge clk_i) begin
    mem_ack_i = 1'b0;
    if (rst_i || !mem_req_o) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy   = 1'b1;
        left   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        c_addr = mem_addr_o; c_we = mem_we_o; c_wd = mem_wdata_o;
      end else begin
        n_chk++;
        if (mem_addr_o !== c_addr || mem_we_o !== c_we || (c_we && mem_wdata_o !== c_wd)) begin
          n_fail++;
          $display("FAIL mem_stable: got a=%h we=%b d=%h expected a=%h we=%b d=%h",
                   mem_addr_o, mem_we_o, mem_wdata_o, c_addr, c_we, c_wd);
        end
      end
      left--;
      if (left == 0) begin
        mem_ack_i = 1'b1;
        busy = 1'b0;
        ack_cnt++;
        if (c_we) begin
          bmem[c_addr] = c_wd;
          wr_log.push_back({c_addr, c_wd});
        end else begin
          mem_rdata_i = bmem.exists(c_addr) ? bmem[c_addr] : init_word(c_addr);
          rd_log.push_back(c_addr);
        end
      end
    end
  end

  // ---------------- reference model: line presence + word image ----------
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_mem   [logic [31:0]];
  logic [31:0] m_hits = 0, m_miss = 0;

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_miss = 0;
  endtask

  // Monitor: a completing request (held, not stalled) must match the head
  always @(negedge clk_i) begin
    if (!rst_i && (rd_i || wr_i) && !stall_o) begin
      exp_t e;
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got completion at %h expected none", addr_i);
      end else begin
        e = sbq.pop_front();
        if (e.is_rd && rdata_o !== e.data) begin
          n_fail++;
          $display("FAIL rdata @%h: got %h expected %h", e.addr, rdata_o, e.data);
        end else if (mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL req_at_done @%h: got %b expected 0", e.addr, mem_req_o);
        end
      end
    end
  end

  // Driver: called at posedge+1; issues one CPU access and waits it out
  task automatic cpu(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] a;
    int idx, waited;
    bit hit, done;
    exp_t e;
    a   = {addr[31:2], 2'b00};
    idx = int'((a >> 4) % 16);
    hit = m_valid[idx] && m_tag[idx] == (a >> 8);
    if (wr) begin
      if (hit) m_hits = sat(m_hits); else m_miss = sat(m_miss);
      m_mem[a] = wd;
    end else if (rd) begin
      if (hit) m_hits = sat(m_hits);
      else begin m_miss = sat(m_miss); m_valid[idx] = 1'b1; m_tag[idx] = a >> 8; end
    end
    e.is_rd = rd && !wr; e.addr = a; e.data = m_rd(a);
    sbq.push_back(e);
    rd_i = rd; wr_i = wr; addr_i = addr; wdata_i = wd;
    waited = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_i);
      if (!stall_o) done = 1'b1; else waited++;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout @%h: got stall for 300 cycles expected completion", a);
      finish_test();
    end
    chk("zero_wait_iff_read_hit", 32'(waited == 0), 32'(rd && !wr && hit));
    @(posedge clk_i); #1;
    rd_i = 1'b0; wr_i = 1'b0;
    chk("hit_cnt", hit_cnt_o, m_hits);
    chk("miss_cnt", miss_cnt_o, m_miss);
  endtask

  logic [31:0] m0, tmp;
  int base;

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_hit", hit_cnt_o, 0);
    chk("rst_miss", miss_cnt_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_rdata", rdata_o, 0);
    rst_i = 1'b0;

    // 1: cold read miss, 2-cycle words, full line fetched in order
    fixed_lat = 2; rd_log.delete();
    cpu(1, 0, 32'h40, 0);
    chk("refill_n", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      chk("refill_addr", rd_log[i], 32'h40 + 32'(4 * i));

    // 2: same line hit
    cpu(1, 0, 32'h48, 0);

    // 3: write hit goes through with a 3-cycle ack, then read it back
    fixed_lat = 3; wr_log.delete();
    cpu(0, 1, 32'h44, 32'hDEAD_BEEF);
    chk("wr_n", wr_log.size(), 1);
    if (wr_log.size() > 0) begin
      tmp = wr_log[0][63:32]; chk("wr_addr", tmp, 32'h44);
      tmp = wr_log[0][31:0];  chk("wr_data", tmp, 32'hDEAD_BEEF);
    end
    cpu(1, 0, 32'h44, 0);

    // 4: write miss does not allocate
    fixed_lat = 0; m0 = miss_cnt_o;
    cpu(0, 1, 32'h200, 32'h1234_5678);
    cpu(1, 0, 32'h200, 0);
    chk("wmiss_delta", miss_cnt_o - m0, 2);

    // 5: conflict eviction, then reset in the middle of a refill
    cpu(1, 0, 32'h140, 0);
    cpu(1, 0, 32'h40, 0);
    fixed_lat = 1;
    base = ack_cnt;
    rd_i = 1'b1; addr_i = 32'h300;
    for (int c = 0; c < 50 && ack_cnt < base + 2; c++) @(posedge clk_i);
    chk("abort_acks", 32'(ack_cnt >= base + 2), 1);
    #1; rst_i = 1'b1; rd_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0;
    model_reset();
    chk("abort_hit", hit_cnt_o, 0);
    chk("abort_miss", miss_cnt_o, 0);
    cpu(1, 0, 32'h300, 0);

    // 6: hit counter saturation
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_hit_cnt;
    m_hits = 32'hFFFF_FFFE;
    @(posedge clk_i); #1;
    cpu(1, 0, 32'h300, 0);
    cpu(1, 0, 32'h304, 0);
    cpu(1, 0, 32'h308, 0);
    chk("hit_sat", hit_cnt_o, 32'hFFFF_FFFF);

    // random mix over a small footprint for hits, conflicts and write-through
    rst_i = 1'b1; @(posedge clk_i); #1; rst_i = 1'b0; model_reset();
    fixed_lat = 0;
    for (int n = 0; n < 120; n++) begin
      int op;
      logic [31:0] ra;
      op = int'($urandom_range(0, 3));
      ra = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      cpu(op != 2, op >= 2, ra, $urandom);
    end
    chk("sb_drained", sbq.size(), 0);
    finish_test();
  end
endmodule
